// File: rtl/cic_pkg.sv
// Shared types and constants for the CIC decimation-chain controller.
package cic_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        CLEAR  = 2'd2,
        WARMUP = 2'd3
    } cic_state_t;

    localparam int MIN_RATE      = 2;
    localparam int DEF_RW        = 16;
    localparam int DEF_R_DEFAULT = 100;

endpackage

// File: rtl/cic_out_buf.sv
// Single-entry valid/ready holding register for the comb output, with drop detection.
// Optional feature macro: CIC_CTRL_OVERRUN_EN (sticky overrun flag and saturating drop counter).
module cic_out_buf #(
    parameter int OW = 128
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_en,
    input  logic          i_flush,
    input  logic [OW-1:0] i_data,
    input  logic          i_valid,
    input  logic          i_ready,
    output logic [OW-1:0] o_data,
    output logic          o_valid,
    output logic          o_overrun
`ifdef CIC_CTRL_OVERRUN_EN
    , output logic [15:0] o_overrun_cnt
`endif
);

    logic [OW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          take_s;

    // Accept a new sample when the slot is empty or being emptied this cycle.
    always_comb begin
        take_s  = i_en && i_valid && (!valid_q || i_ready);
        data_d  = data_q;
        valid_d = valid_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (take_s) begin
            data_d  = i_data;
            valid_d = 1'b1;
        end else if (i_en && valid_q && i_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Holding register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_q  <= {OW{1'b0}};
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

`ifdef CIC_CTRL_OVERRUN_EN
    logic        drop_s;
    logic        ovr_q;
    logic [15:0] ovr_cnt_q;

    assign drop_s = i_en && i_valid && valid_q && !i_ready;

    // Sticky overrun flag and saturating count of dropped samples.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ovr_q     <= 1'b0;
            ovr_cnt_q <= 16'd0;
        end else if (drop_s) begin
            ovr_q <= 1'b1;
            if (ovr_cnt_q != 16'hFFFF) begin
                ovr_cnt_q <= ovr_cnt_q + 16'd1;
            end
        end
    end

    assign o_overrun     = ovr_q;
    assign o_overrun_cnt = ovr_cnt_q;
`else
    assign o_overrun = 1'b0;
`endif

endmodule

// File: rtl/cic_ctrl.sv
// CIC chain sequencer: sample-strobe counting, rate changes at decimation boundaries, output hold.
// Optional feature macro: CIC_CTRL_OVERRUN_EN (adds o_overrun_cnt and enables o_overrun).
module cic_ctrl
    import cic_pkg::*;
#(
    parameter int RW        = DEF_RW,
    parameter int OW        = 128,
    parameter int M         = 10,
    parameter int R_DEFAULT = DEF_R_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic [RW-1:0] i_rate,
    input  logic          i_rate_wr,
    output logic          o_rate_busy,
    output logic          o_int_ce,
    output logic          o_dec_ce,
    output logic          o_clear,
    input  logic [OW-1:0] i_comb_data,
    input  logic          i_comb_valid,
    output logic [OW-1:0] o_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_overrun
`ifdef CIC_CTRL_OVERRUN_EN
    , output logic [15:0] o_overrun_cnt
`endif
);

    localparam int WW = $clog2(M + 1);

    cic_state_t    state_q, state_d;
    logic [RW-1:0] rate_q, rate_d;
    logic [RW-1:0] pend_q, pend_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] warm_q, warm_d;
    logic          dec_hit_s;

    // Strobes, counters and sequencing FSM next state.
    always_comb begin
        dec_hit_s = (cnt_q == (rate_q - {{(RW-1){1'b0}}, 1'b1}));
        o_int_ce  = i_ce && (state_q != CLEAR);
        o_dec_ce  = o_int_ce && dec_hit_s;
        state_d   = state_q;
        rate_d    = rate_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        warm_d    = warm_q;
        if (o_int_ce) begin
            cnt_d = dec_hit_s ? {RW{1'b0}} : (cnt_q + {{(RW-1){1'b0}}, 1'b1});
        end else begin
            cnt_d = cnt_q;
        end
        case (state_q)
            RUN: begin
                if (i_rate_wr && (i_rate >= RW'(MIN_RATE))) begin
                    pend_d  = i_rate;
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                state_d = o_dec_ce ? CLEAR : DRAIN;
            end
            CLEAR: begin
                rate_d  = pend_q;
                cnt_d   = {RW{1'b0}};
                warm_d  = {WW{1'b0}};
                state_d = WARMUP;
            end
            WARMUP: begin
                if (i_comb_valid) begin
                    warm_d  = warm_q + {{(WW-1){1'b0}}, 1'b1};
                    state_d = (warm_q == WW'(M - 1)) ? RUN : WARMUP;
                end else begin
                    state_d = WARMUP;
                end
            end
            default: begin
                state_d = WARMUP;
            end
        endcase
    end

    // Sequencer state; reset discards any pending rate.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= WARMUP;
            rate_q  <= RW'(R_DEFAULT);
            pend_q  <= RW'(R_DEFAULT);
            cnt_q   <= {RW{1'b0}};
            warm_q  <= {WW{1'b0}};
        end else begin
            state_q <= state_d;
            rate_q  <= rate_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            warm_q  <= warm_d;
        end
    end

    assign o_rate_busy = (state_q != RUN);
    assign o_clear     = (state_q == CLEAR);

    cic_out_buf #(
        .OW(OW)
    ) u_out_buf (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_en          ((state_q == RUN) || (state_q == DRAIN)),
        .i_flush       (state_q == CLEAR),
        .i_data        (i_comb_data),
        .i_valid       (i_comb_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_overrun     (o_overrun)
`ifdef CIC_CTRL_OVERRUN_EN
        , .o_overrun_cnt(o_overrun_cnt)
`endif
    );

endmodule

// File: tb/tb_cic_ctrl.sv
// Randomized scoreboard bench for cic_ctrl against a behavioural model of the sequencing rules.
module tb_cic_ctrl;

    localparam int RW = 16;
    localparam int OW = 32;
    localparam int M  = 3;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          i_reset, i_ce, i_rate_wr, i_comb_valid, i_ready;
    logic [RW-1:0] i_rate;
    logic [OW-1:0] i_comb_data;
    logic          o_rate_busy, o_int_ce, o_dec_ce, o_clear, o_valid, o_overrun;
    logic [OW-1:0] o_data;
`ifdef CIC_CTRL_OVERRUN_EN
    logic [15:0]   o_overrun_cnt;
`endif

    always #5 clk = ~clk;

    cic_ctrl #(.RW(RW), .OW(OW), .M(M), .R_DEFAULT(RD)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_rate(i_rate),
        .i_rate_wr(i_rate_wr), .o_rate_busy(o_rate_busy), .o_int_ce(o_int_ce),
        .o_dec_ce(o_dec_ce), .o_clear(o_clear), .i_comb_data(i_comb_data),
        .i_comb_valid(i_comb_valid), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_overrun(o_overrun)
`ifdef CIC_CTRL_OVERRUN_EN
        , .o_overrun_cnt(o_overrun_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [OW-1:0] exp_q[$];

    // Behavioural model: samples counted since the last clear, phase flags, held slot.
    int m_rate, m_pend, m_cnt, m_warm, m_ovr_cnt;
    bit m_drain, m_clear, m_held, m_ovr;
    logic [OW-1:0] last_data;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rate = RD; m_pend = RD; m_cnt = 0; m_warm = M; m_ovr_cnt = 0;
        m_drain = 0; m_clear = 0; m_held = 0; m_ovr = 0;
        exp_q.delete();
    endtask

    // Monitor: every accepted output must match the oldest expected sample.
    always @(negedge clk) begin : monitor
        logic [OW-1:0] e;
        if (!i_reset && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_data: unexpected sample %0h, nothing expected", o_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", o_data, e);
            end
        end
    end

    task automatic step();
        bit run, dec;
        @(negedge clk);
        run = !m_drain && !m_clear && (m_warm == 0);
        dec = i_ce && !m_clear && ((m_cnt % m_rate) == (m_rate - 1));
        chk("int_ce", o_int_ce, i_ce && !m_clear);
        chk("dec_ce", o_dec_ce, dec);
        chk("rate_busy", o_rate_busy, !run);
        chk("clear", o_clear, m_clear);
        chk("valid", o_valid, m_held);
        chk("overrun", o_overrun, m_ovr);
`ifdef CIC_CTRL_OVERRUN_EN
        chk("overrun_cnt", o_overrun_cnt, m_ovr_cnt);
`endif
        @(posedge clk);
        if (i_reset) begin
            model_reset();
        end else begin
            if (m_clear) begin
                if (m_held && !i_ready) void'(exp_q.pop_back());
                m_held = 0;
            end else if (m_warm == 0) begin
                if (i_comb_valid) begin
                    if (!m_held || i_ready) begin
                        exp_q.push_back(i_comb_data);
                        m_held = 1;
                    end else begin
`ifdef CIC_CTRL_OVERRUN_EN
                        m_ovr = 1;
                        if (m_ovr_cnt < 65535) m_ovr_cnt++;
`endif
                    end
                end else if (m_held && i_ready) begin
                    m_held = 0;
                end
            end
            if (m_clear) begin
                m_rate = m_pend; m_cnt = 0; m_clear = 0; m_warm = M;
            end else begin
                if (i_ce) m_cnt++;
                if (m_drain) begin
                    if (dec) begin m_drain = 0; m_clear = 1; end
                end else if (m_warm > 0) begin
                    if (i_comb_valid) m_warm--;
                end else if (run && i_rate_wr && (int'(i_rate) >= 2)) begin
                    m_pend = int'(i_rate);
                    m_drain = 1;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input bit ce, input bit cv, input bit rdy, input bit wr, input int rate);
        logic [31:0] r;
        r = rate;
        i_ce = ce; i_comb_valid = cv; i_ready = rdy; i_rate_wr = wr;
        i_rate = r[RW-1:0];
        last_data = $urandom;
        i_comb_data = last_data;
        step();
    endtask

    initial begin
        logic [OW-1:0] first_data;
        bit reached;
        i_reset = 1'b1; i_ce = 1'b0; i_rate_wr = 1'b0; i_rate = '0;
        i_comb_valid = 1'b0; i_comb_data = '0; i_ready = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        step();
        chk("data_reset", o_data, 0);
        i_reset = 1'b0;

        // Warm-up out of reset, then steady decimation by 4.
        for (int i = 0; i < 30; i++) drive(1, (i % 2) == 1, 1, 0, 0);
        // Rate change to 8 mid-count.
        drive(1, 0, 1, 1, 8);
        for (int i = 0; i < 40; i++) drive(1, (i % 3) == 0, 1, 0, 0);
        // Illegal rate ignored; write while busy ignored.
        drive(1, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) drive(1, 0, 1, 0, 0);
        drive(1, 0, 1, 1, 6);
        drive(1, 0, 1, 1, 9);
        for (int i = 0; i < 30; i++) drive(1, (i % 2) == 1, 1, 0, 0);

        // Backpressure: second sample while full is dropped.
        drive(0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0);
        first_data = last_data;
        drive(0, 0, 0, 0, 0);
        chk("held_data", o_data, first_data);
        drive(0, 1, 0, 0, 0);
        chk("held_after_drop", o_data, first_data);
        drive(0, 0, 0, 0, 0);
        chk("held_data2", o_data, first_data);
        drive(0, 0, 1, 0, 0);

        // Reset during the warm-up that follows a rate write.
        drive(1, 0, 1, 1, 5);
        reached = 0;
        for (int i = 0; i < 20 && !reached; i++) begin
            drive(1, 0, 1, 0, 0);
            reached = (m_warm > 0) && !m_clear && !m_drain;
        end
        chk("warmup_reached", reached, 1);
        i_reset = 1'b1;
        drive(1, 0, 1, 0, 0);
        i_reset = 1'b0;
        chk("data_after_reset", o_data, 0);
        for (int i = 0; i < 40; i++) drive(1, (i % 2) == 0, 1, 0, 0);

        // Randomized traffic with occasional rate writes and resets.
        for (int i = 0; i < 2500; i++) begin
            i_reset = ($urandom % 400) == 0;
            drive(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 4) != 0,
                  ($urandom % 40) == 0, int'($urandom_range(0, 12)));
        end
        i_reset = 1'b0;
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cic_ctrl.md
# cic_ctrl

Sequencing controller for the CIC decimation chain. It counts input sample strobes to generate the integrator and decimation enables. It also applies runtime decimation-rate changes at a decimation boundary: it clears the integrator/comb state and discards the comb-section warm-up outputs. Finally, it presents the comb output to the downstream consumer through a single-entry valid/ready holding register. It sits beside the integrator→decimator→comb datapath and owns all of that datapath's enables and clears.

## Interface
- RW, 16: width of decimation-rate register
- OW, 128: datapath width (comb output)
- M, 10: number of comb outputs discarded after a clear (warm-up)
- R_DEFAULT, 100: rate loaded at reset; legal range 2..2^RW-1

- i_clk  in  1  clock
- i_reset  in  1  reset; synchronous, active-high
- i_ce  in  1  input sample strobe
- i_rate  in  RW  requested decimation rate
- i_rate_wr  in  1  rate write strobe
- o_rate_busy  out  RW-indep 1  rate change pending or in progress
- o_int_ce  out  1  integrator enable (combinational)
- o_dec_ce  out  1  decimation strobe to comb section (combinational)
- o_clear  out  1  synchronous clear to integrators/combs
- i_comb_data  in  OW  comb chain output
- i_comb_valid  in  1  comb chain output strobe
- o_data  out  OW  held output sample
- o_valid  out  1  o_data valid
- i_ready  in  1  downstream accepts o_data
- o_overrun  out  1  sticky: comb sample dropped

## Operation
- States: RUN, DRAIN, CLEAR, WARMUP. Reset state is WARMUP.
- Reset values:
  - rate_q=R_DEFAULT, cnt=0, warm_cnt=0
  - o_rate_busy=1, o_clear=0, o_valid=0, o_data=0, o_overrun=0
- cnt counts i_ce modulo rate_q.
  - o_dec_ce = i_ce & (cnt==rate_q-1) & state!=CLEAR.
  - o_int_ce = i_ce & state!=CLEAR.
- Rate write:
  - Accepted only in RUN with 2 ≤ i_rate. Otherwise it is ignored and the state is unchanged.
  - On acceptance: pend_q ← i_rate, state → DRAIN, o_rate_busy=1 next cycle.
- DRAIN: counting continues. The first o_dec_ce after entry moves to CLEAR. A dec_ce in the same cycle as the accepting write does not count.
- CLEAR lasts exactly one cycle:
  - o_clear=1, rate_q ← pend_q, cnt ← 0, warm_cnt ← 0, o_valid ← 0.
  - An i_ce in this cycle is dropped.
  - Next state is WARMUP.
- WARMUP: each i_comb_valid increments warm_cnt and its data is discarded. At the M-th one, state → RUN and o_rate_busy ← 0.
- Output register (RUN and DRAIN only):
  - i_comb_valid with (!o_valid | i_ready): o_data ← i_comb_data, o_valid ← 1.
  - i_comb_valid with o_valid & !i_ready: the new sample is dropped and o_overrun ← 1.
  - o_valid & i_ready with no new sample: o_valid ← 0.
- Width rule: cnt is RW bits; the comparison is against rate_q-1. Wrap to 0 on dec_ce.
- Reset mid-operation, including during DRAIN or WARMUP, discards pend_q and returns to the reset state.

## Timing
- o_int_ce and o_dec_ce: 0-cycle, combinational from i_ce.
- o_rate_busy rises 1 cycle after an accepted i_rate_wr.
- o_clear pulses the cycle after the boundary o_dec_ce in DRAIN.
- o_data/o_valid follow i_comb_valid by 1 cycle.
- Back-to-back transfers at one per cycle are supported when i_ready is held at 1.
- o_overrun and the output registers update on the i_clk rising edge.

## Configuration
- CIC_CTRL_OVERRUN_EN defined: o_overrun behaves as above, and o_overrun_cnt (out, 16) counts dropped samples, saturating at 0xFFFF. Both are reset to 0.
- Not defined: o_overrun tied 0 and o_overrun_cnt absent. Samples arriving while the register is full are still dropped silently.

## Structure
- Package cic_pkg holds:
  - state enum (RUN, DRAIN, CLEAR, WARMUP)
  - MIN_RATE=2
  - default RW and R_DEFAULT constants
- Sub-module cic_out_buf: single-entry holding register with valid/ready and drop/overrun detection. It is instantiated once.
- The FSM, rate counter and warm-up counter stay in cic_ctrl.

## Test plan
- Reset, M=3, R_DEFAULT=4, i_ce every cycle:
  - o_dec_ce every 4th i_ce.
  - First 3 i_comb_valid are discarded.
  - o_rate_busy falls after the 3rd, and the 4th sample appears on o_data 1 cycle later.
- In RUN, write i_rate=8 mid-count:
  - o_rate_busy=1 next cycle.
  - o_clear single pulse the cycle after the next dec_ce.
  - o_dec_ce then every 8th i_ce.
- Write i_rate=1, then i_rate=8 while busy: both are ignored, with rate and state unchanged.
- Hold i_ready=0 across two i_comb_valid:
  - First sample is held.
  - Second is dropped and o_overrun=1 (o_overrun_cnt=1 with CIC_CTRL_OVERRUN_EN).
  - o_data is unchanged until i_ready.
- Assert i_reset during WARMUP following a rate write:
  - rate_q=R_DEFAULT and all outputs return to reset values.
  - The pending rate is never applied.
